// File: rtl/mmio_uart_rx.sv
// Memory-mapped UART receiver: synchronised 8N1 deserialiser feeding an 8-bit receive FIFO read via DATA/STATUS loads.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 with a PARITY state and a sticky parity_err flag.
module mmio_uart_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd,
  input  logic        addr,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e        state_q, state_d;
  logic          rx_s1_q, rx_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          rx_sync, mid_tick, bit_tick;
  logic          push, frame_set, push_ok, pop, overrun_set, clr;
  logic [AW:0]   fifo_cnt;
  logic          empty, full, parity_flag;
  logic [31:0]   status;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d, parity_set;
  assign parity_flag = parity_err_q;
`else
  assign parity_flag = 1'b0;
`endif

  assign rx_sync  = rx_s2_q;
  assign mid_tick = (cnt_q == CW'(CPB / 2 - 1));
  assign bit_tick = (cnt_q == CW'(CPB - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rx_sync) state_d = S_START;
      S_START:  if (mid_tick) state_d = rx_sync ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (bit_tick && idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_tick) state_d = S_STOP;
`else
      S_DATA:   if (bit_tick && idx_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:   if (bit_tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: frame-level events raised on the sampling cycle
  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    if (state_q == S_STOP && bit_tick) begin
`ifdef UART_RX_PARITY_EN
      push      = rx_sync & ~par_bad_q;
`else
      push      = rx_sync;
`endif
      frame_set = ~rx_sync;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_set = (state_q == S_PARITY) && bit_tick && ((^shift_q) ^ rx_sync);
`endif

  // Receive datapath: baud counter, bit index, LSB-first shifter
  always_comb begin
    cnt_d   = (state_q == S_IDLE || state_d != state_q || bit_tick) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    if (state_q == S_START) idx_d = 3'd0;
    if (state_q == S_DATA && bit_tick) begin
      idx_d   = idx_q + 3'd1;
      shift_d = {rx_sync, shift_q[7:1]};
    end
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    if (state_q == S_START) par_bad_d = 1'b0;
    if (parity_set) par_bad_d = 1'b1;
`endif
  end

  assign fifo_cnt = wr_ptr_q - rd_ptr_q;
  assign empty    = (fifo_cnt == '0);
  assign full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign status   = {16'b0, 8'(fifo_cnt), 4'b0, parity_flag, frame_err_q, overrun_q, ~empty};

  // A same-cycle pop frees the slot, so a push into a full FIFO still succeeds.
  always_comb begin
    pop         = rd & ~addr & ~empty;
    clr         = rd & addr;
    push_ok     = push & (~full | pop);
    overrun_set = push & full & ~pop;
    wr_ptr_d    = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    overrun_d   = (overrun_q & ~clr) | overrun_set;
    frame_err_d = (frame_err_q & ~clr) | frame_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (parity_err_q & ~clr) | parity_set;
`endif
    rvalid_d = rd;
    rdata_d  = rdata_q;
    if (rd) begin
      if (addr)       rdata_d = status;
      else if (empty) rdata_d = 32'h8000_0000;
      else            rdata_d = {24'b0, mem_q[rd_ptr_q[AW-1:0]]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = ~empty | overrun_q | frame_err_q | parity_flag;

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Bench for mmio_uart_rx at CLKS_PER_BIT = 16, FIFO_DEPTH = 4; received bytes are tracked in an expected-byte queue.
module tb_mmio_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PUSH_OFS = 154 + CPB;
`else
  localparam int PUSH_OFS = 154;
`endif

  logic        clk = 1'b0;
  logic        rst, rx, rd, addr;
  logic [31:0] rdata;
  logic        rvalid, irq;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  mmio_uart_rx #(.CLK_HZ(CPB), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd(rd), .addr(addr),
    .rdata(rdata), .rvalid(rvalid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wait_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Starts on the next rising edge; leaves 20 idle cycles after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip_par);
    @(posedge clk); #1;
    rx = 1'b0; wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; wait_bit();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ flip_par; wait_bit();
`endif
    rx = stop; wait_bit();
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d, output logic v);
    rd = 1'b1; addr = a;
    @(posedge clk); #1;
    rd = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1; rx = 1'b1; rd = 1'b0; addr = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want %h", rdata, 32'd0); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want %h", d, 32'd0); end
  endtask

  task automatic test_single_byte();
    logic [31:0] d; logic v; logic [7:0] e;
    send_frame(8'h55, 1'b1, 1'b0); exp_q.push_back(8'h55);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq got %b want 1", irq); end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'h0000_0101) begin n_fail++; $display("FAIL single_status got %h want %h", d, 32'h101); end
    bus_read(1'b0, d, v);
    e = exp_q.pop_front();
    n_checks++; if (d !== {24'b0, e}) begin n_fail++; $display("FAIL single_data got %h want %h", d, {24'b0, e}); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL single_rvalid got %b want 1", v); end
    @(posedge clk); #1;
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_drop got %b want 0", rvalid); end
    n_checks++; if (rdata !== {24'b0, e}) begin n_fail++; $display("FAIL single_hold got %h want %h", rdata, {24'b0, e}); end
    bus_read(1'b0, d, v);
    n_checks++; if (d !== 32'h8000_0000) begin n_fail++; $display("FAIL single_empty got %h want %h", d, 32'h8000_0000); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d; logic v; logic [7:0] e;
    rx = 1'b0; repeat (4) @(posedge clk); #1;
    rx = 1'b1; repeat (30) @(posedge clk); #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq got %b want 0", irq); end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL glitch_status got %h want %h", d, 32'd0); end
    send_frame(8'h5A, 1'b1, 1'b0); exp_q.push_back(8'h5A);
    bus_read(1'b0, d, v); e = exp_q.pop_front();
    n_checks++; if (d !== {24'b0, e}) begin n_fail++; $display("FAIL glitch_after got %h want %h", d, {24'b0, e}); end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic v; logic [7:0] e;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 1'b0);
      if (b <= DEPTH) exp_q.push_back(8'(b));
    end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL overrun_irq got %b want 1", irq); end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'h0000_0403) begin n_fail++; $display("FAIL overrun_status got %h want %h", d, 32'h403); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(1'b0, d, v); e = exp_q.pop_front();
      n_checks++; if (d !== {24'b0, e}) begin n_fail++; $display("FAIL overrun_data%0d got %h want %h", i, d, {24'b0, e}); end
    end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL overrun_clear got %h want %h", d, 32'd0); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d; logic v;
    send_frame(8'hA5, 1'b0, 1'b0);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL frame_irq got %b want 1", irq); end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'h0000_0004) begin n_fail++; $display("FAIL frame_status got %h want %h", d, 32'h4); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL frame_irq_clear got %b want 0", irq); end
    bus_read(1'b0, d, v);
    n_checks++; if (d !== 32'h8000_0000) begin n_fail++; $display("FAIL frame_empty got %h want %h", d, 32'h8000_0000); end
  endtask

  task automatic test_push_pop();
    logic [31:0] d; logic v; logic [7:0] e;
    for (int b = 0; b < DEPTH; b++) begin
      send_frame(8'(8'h10 + b), 1'b1, 1'b0); exp_q.push_back(8'(8'h10 + b));
    end
    fork
      send_frame(8'h14, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (PUSH_OFS) @(posedge clk);
        #1; rd = 1'b1; addr = 1'b0;
        @(posedge clk); #1;
        rd = 1'b0; d = rdata;
      end
    join
    e = exp_q.pop_front(); exp_q.push_back(8'h14);
    n_checks++; if (d !== {24'b0, e}) begin n_fail++; $display("FAIL pushpop_data got %h want %h", d, {24'b0, e}); end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'h0000_0401) begin n_fail++; $display("FAIL pushpop_status got %h want %h", d, 32'h401); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(1'b0, d, v); e = exp_q.pop_front();
      n_checks++; if (d !== {24'b0, e}) begin n_fail++; $display("FAIL pushpop_drain%0d got %h want %h", i, d, {24'b0, e}); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v; logic [7:0] e;
    send_frame(8'h77, 1'b1, 1'b0); exp_q.push_back(8'h77);
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (CPB * 4 + 8) @(posedge clk);
        #1; rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq got %b want 0", irq); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_rdata got %h want %h", rdata, 32'd0); end
        rst = 1'b0;
      end
    join
    exp_q.delete();
    send_frame(8'h3C, 1'b1, 1'b0); exp_q.push_back(8'h3C);
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'h0000_0101) begin n_fail++; $display("FAIL midrst_status got %h want %h", d, 32'h101); end
    bus_read(1'b0, d, v); e = exp_q.pop_front();
    n_checks++; if (d !== {24'b0, e}) begin n_fail++; $display("FAIL midrst_data got %h want %h", d, {24'b0, e}); end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_flags got %h want %h", d, 32'd0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    send_frame(8'hC1, 1'b1, 1'b0); exp_q.push_back(8'hC1);
    send_frame(8'hC2, 1'b1, 1'b0); exp_q.push_back(8'hC2);
    send_frame(8'hC3, 1'b1, 1'b0); exp_q.push_back(8'hC3);
    rd = 1'b1; addr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid%0d got %b want 1", i, rvalid); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (rdata !== {24'b0, e}) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, rdata, {24'b0, e}); end
      end else begin
        n_checks++; if (rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_empty got %h want %h", rdata, 32'h8000_0000); end
      end
    end
    rd = 1'b0;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] d; logic v; logic [7:0] e;
    send_frame(8'h03, 1'b1, 1'b0); exp_q.push_back(8'h03);
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'h0000_0101) begin n_fail++; $display("FAIL parity_ok_status got %h want %h", d, 32'h101); end
    bus_read(1'b0, d, v); e = exp_q.pop_front();
    n_checks++; if (d !== {24'b0, e}) begin n_fail++; $display("FAIL parity_ok_data got %h want %h", d, {24'b0, e}); end
    send_frame(8'h03, 1'b1, 1'b1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL parity_irq got %b want 1", irq); end
    bus_read(1'b1, d, v);
    n_checks++; if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL parity_bad_status got %h want %h", d, 32'h8); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_push_pop();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
